// File: rtl/dmem_sram.sv
// Word-addressed data memory with byte-masked writes and a READ_LATENCY-deep read pipeline.
// Reads complete READ_LATENCY edges after issue, one per cycle; no backpressure.
module dmem_sram #(
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              csb_write_i,
  input  logic [3:0]        wmask_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       din_i,
  input  logic              csb_read_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       dout_o,
  output logic              dout_valid_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("dmem_sram: READ_LATENCY must be within 1..4");
  end
  if (DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("dmem_sram: DEPTH must not exceed 2**ADDR_W");
  end

  logic [31:0]             mem [DEPTH];
  logic [IDX_W-1:0]        widx;
  logic [IDX_W-1:0]        ridx;
  logic                    wr_en;
  logic                    rd_en;
  logic [31:0]             wr_word;
  logic [31:0]             rd_word;
  logic [31:0]             pipe_dat [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_vld;

  assign widx  = waddr_i[IDX_W-1:0];
  assign ridx  = raddr_i[IDX_W-1:0];
  assign wr_en = ~csb_write_i;
  assign rd_en = ~csb_read_i;

  // The merged word doubles as the write-first bypass for a same-edge read.
  always_comb begin
    wr_word = mem[widx];
    for (int b = 0; b < 4; b++) begin
      if (wmask_i[b]) begin
        wr_word[8*b +: 8] = din_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[ridx];
    if (wr_en && (widx == ridx)) begin
      rd_word = wr_word;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[widx] <= wr_word;
    end
  end

  // Each stage only loads when its predecessor is valid, so the last stage holds between reads.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pipe_vld <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_dat[k] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_en;
      if (rd_en) begin
        pipe_dat[0] <= rd_word;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        if (pipe_vld[k-1]) begin
          pipe_dat[k] <= pipe_dat[k-1];
        end
      end
    end
  end

  assign dout_o       = pipe_dat[READ_LATENCY-1];
  assign dout_valid_o = pipe_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_dmem_sram.sv
// Bench for dmem_sram: three instances (latency 1, latency 3, depth 64) share one stimulus stream.
module tb_dmem_sram;

  logic        clk;
  logic        reset_i;
  logic        csb_write_i;
  logic [3:0]  wmask_i;
  logic [7:0]  waddr_i;
  logic [31:0] din_i;
  logic        csb_read_i;
  logic [7:0]  raddr_i;
  logic [31:0] dout1, dout3, dout64;
  logic        vld1, vld3, vld64;

  int total = 0;
  int bad   = 0;

  dmem_sram u1 (
    .clk_i(clk), .reset_i(reset_i), .csb_write_i(csb_write_i), .wmask_i(wmask_i),
    .waddr_i(waddr_i), .din_i(din_i), .csb_read_i(csb_read_i), .raddr_i(raddr_i),
    .dout_o(dout1), .dout_valid_o(vld1)
  );

  dmem_sram #(.READ_LATENCY(3)) u3 (
    .clk_i(clk), .reset_i(reset_i), .csb_write_i(csb_write_i), .wmask_i(wmask_i),
    .waddr_i(waddr_i), .din_i(din_i), .csb_read_i(csb_read_i), .raddr_i(raddr_i),
    .dout_o(dout3), .dout_valid_o(vld3)
  );

  dmem_sram #(.DEPTH(64)) u64 (
    .clk_i(clk), .reset_i(reset_i), .csb_write_i(csb_write_i), .wmask_i(wmask_i),
    .waddr_i(waddr_i), .din_i(din_i), .csb_read_i(csb_read_i), .raddr_i(raddr_i),
    .dout_o(dout64), .dout_valid_o(vld64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain memories plus, per instance, a history of issued reads.
  logic [31:0] m256 [256];
  logic [31:0] m64  [64];
  logic        hv [3][4];
  logic [31:0] hd [3][4];
  logic        ev [3];
  logic [31:0] ed [3];

  function automatic int lat_of(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic hit);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (hit && !csb_write_i && wmask_i[b]) r[8*b +: 8] = din_i[8*b +: 8];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 256; a++) m256[a] = '0;
    for (int a = 0; a < 64; a++) m64[a] = '0;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin
        hv[i][k] = 1'b0;
        hd[i][k] = '0;
      end
      ev[i] = 1'b0;
      ed[i] = '0;
    end
  endtask

  task automatic model_edge();
    logic [31:0] r256;
    logic [31:0] r64;
    int          wi64;
    int          ri64;
    if (!reset_i) return;
    wi64 = int'(waddr_i) % 64;
    ri64 = int'(raddr_i) % 64;
    r256 = merge(m256[raddr_i], raddr_i == waddr_i);
    r64  = merge(m64[ri64], ri64 == wi64);
    for (int i = 0; i < 3; i++) begin
      for (int k = 3; k > 0; k--) begin
        hv[i][k] = hv[i][k-1];
        hd[i][k] = hd[i][k-1];
      end
      hv[i][0] = !csb_read_i;
      hd[i][0] = (i == 2) ? r64 : r256;
      ev[i] = hv[i][lat_of(i)-1];
      if (ev[i]) ed[i] = hd[i][lat_of(i)-1];
    end
    if (!csb_write_i) begin
      m256[waddr_i] = merge(m256[waddr_i], 1'b1);
      m64[wi64]     = merge(m64[wi64], 1'b1);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all();
    chk("u1_dout",  dout1,  ed[0]);
    chk("u1_vld",   {31'b0, vld1},  {31'b0, ev[0]});
    chk("u3_dout",  dout3,  ed[1]);
    chk("u3_vld",   {31'b0, vld3},  {31'b0, ev[1]});
    chk("u64_dout", dout64, ed[2]);
    chk("u64_vld",  {31'b0, vld64}, {31'b0, ev[2]});
  endtask

  task automatic drive(input logic wcs, input logic [3:0] m, input logic [7:0] wa,
                       input logic [31:0] d, input logic rcs, input logic [7:0] ra);
    csb_write_i = wcs;
    wmask_i     = m;
    waddr_i     = wa;
    din_i       = d;
    csb_read_i  = rcs;
    raddr_i     = ra;
  endtask

  task automatic idle();
    drive(1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  function automatic logic [7:0] rnd_addr();
    logic [7:0] a;
    a = 8'($urandom_range(0, 7));
    a[7:6] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  typedef struct {
    logic        wcs;
    logic [3:0]  mask;
    logic [7:0]  waddr;
    logic [31:0] din;
    logic        rcs;
    logic [7:0]  raddr;
    logic [31:0] exp_dout;
    logic        exp_vld;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 4'h0, 8'h00, 32'h00000000, 1'b0, 8'h00, 32'h00000000, 1'b1};
    tbl[1]  = '{1'b1, 4'h0, 8'h00, 32'h00000000, 1'b0, 8'h7F, 32'h00000000, 1'b1};
    tbl[2]  = '{1'b1, 4'h0, 8'h00, 32'h00000000, 1'b0, 8'hFF, 32'h00000000, 1'b1};
    tbl[3]  = '{1'b0, 4'hF, 8'h10, 32'hDEADBEEF, 1'b1, 8'h00, 32'h00000000, 1'b0};
    tbl[4]  = '{1'b1, 4'h0, 8'h00, 32'h00000000, 1'b0, 8'h10, 32'hDEADBEEF, 1'b1};
    tbl[5]  = '{1'b1, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h00, 32'hDEADBEEF, 1'b0};
    tbl[6]  = '{1'b0, 4'hF, 8'h20, 32'h11223344, 1'b1, 8'h00, 32'hDEADBEEF, 1'b0};
    tbl[7]  = '{1'b0, 4'h5, 8'h20, 32'hAABBCCDD, 1'b1, 8'h00, 32'hDEADBEEF, 1'b0};
    tbl[8]  = '{1'b1, 4'h0, 8'h00, 32'h00000000, 1'b0, 8'h20, 32'h11BB33DD, 1'b1};
    tbl[9]  = '{1'b0, 4'hF, 8'h05, 32'h01020304, 1'b1, 8'h00, 32'h11BB33DD, 1'b0};
    tbl[10] = '{1'b0, 4'h8, 8'h05, 32'hF0F0F0F0, 1'b0, 8'h05, 32'hF0020304, 1'b1};
    tbl[11] = '{1'b1, 4'h0, 8'h00, 32'h00000000, 1'b0, 8'h05, 32'hF0020304, 1'b1};
    tbl[12] = '{1'b0, 4'h0, 8'h05, 32'hFFFFFFFF, 1'b0, 8'h05, 32'hF0020304, 1'b1};

    reset_i = 1'b1;
    idle();
    model_reset();
    #2 reset_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("reset_dout", dout3, 32'h0);
    reset_i = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].wcs, tbl[i].mask, tbl[i].waddr, tbl[i].din, tbl[i].rcs, tbl[i].raddr);
      tick();
      chk($sformatf("tbl%0d_dout", i), dout1, tbl[i].exp_dout);
      chk($sformatf("tbl%0d_vld", i), {31'b0, vld1}, {31'b0, tbl[i].exp_vld});
    end

    // Latency-3 pipelining; the write to 0x01 after its read must not leak into it.
    for (int a = 1; a <= 3; a++) begin
      drive(1'b0, 4'hF, 8'(a), 32'(a), 1'b1, 8'h00);
      tick();
    end
    drive(1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h01);
    tick();
    chk("l3_e0_vld", {31'b0, vld3}, 32'd0);
    drive(1'b0, 4'hF, 8'h01, 32'h99, 1'b0, 8'h02);
    tick();
    chk("l3_e1_vld", {31'b0, vld3}, 32'd0);
    drive(1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h03);
    tick();
    chk("l3_p3_vld", {31'b0, vld3}, 32'd1);
    chk("l3_p3_dout", dout3, 32'd1);
    idle();
    tick();
    chk("l3_p4_vld", {31'b0, vld3}, 32'd1);
    chk("l3_p4_dout", dout3, 32'd2);
    tick();
    chk("l3_p5_vld", {31'b0, vld3}, 32'd1);
    chk("l3_p5_dout", dout3, 32'd3);
    tick();
    chk("l3_p6_vld", {31'b0, vld3}, 32'd0);
    chk("l3_p6_hold", dout3, 32'd3);
    drive(1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h01);
    tick();
    idle();
    tick();
    tick();
    chk("l3_late_dout", dout3, 32'h99);

    // Depth-64 wrap and masked no-op.
    drive(1'b0, 4'hF, 8'h45, 32'hCAFEF00D, 1'b1, 8'h00);
    tick();
    drive(1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h05);
    tick();
    chk("wrap_dout", dout64, 32'hCAFEF00D);
    chk("wrap_vld", {31'b0, vld64}, 32'd1);
    drive(1'b0, 4'h0, 8'h05, 32'h12345678, 1'b1, 8'h00);
    tick();
    drive(1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h05);
    tick();
    chk("noop_dout", dout64, 32'hCAFEF00D);

    // Reset asserted with two latency-3 reads in flight.
    drive(1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h01);
    tick();
    drive(1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h02);
    tick();
    idle();
    reset_i = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_vld", {31'b0, vld3}, 32'd0);
    chk("rst_mid_dout", dout3, 32'd0);
    tick();
    tick();
    reset_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rst_post%0d_vld", i), {31'b0, vld3}, 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      logic [7:0] wa;
      logic [7:0] ra;
      wa = rnd_addr();
      ra = ($urandom_range(0, 3) == 0) ? wa : rnd_addr();
      drive(($urandom_range(0, 99) < 40) ? 1'b0 : 1'b1, 4'($urandom_range(0, 15)), wa,
            $urandom, ($urandom_range(0, 99) < 50) ? 1'b0 : 1'b1, ra);
      tick();
    end

    idle();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
